// File: rtl/fifo_param_if.sv
// ============================================================================
//  Module   : fifo_param_if
//  Brief    : Write/read/status bundle for fifo_param (master = user, slave = FIFO)
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface fifo_param_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   localparam int c_CW = $clog2(DEPTH) + 1;

   logic              wr_en;
   logic [WIDTH-1:0]  din;
   logic              rd_en;
   logic              clr_err;
   logic [WIDTH-1:0]  dout;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [c_CW-1:0]   count;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_en, din, rd_en, clr_err,
      input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  wr_en, din, rd_en, clr_err,
      output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

`default_nettype wire

// File: rtl/fifo_param.sv
// ============================================================================
//  Module   : fifo_param
//  Brief    : Single-clock synchronous FIFO with occupancy count, almost
//             flags and sticky overflow/underflow. Define FIFO_FWFT_EN for
//             first-word-fall-through reads (default: registered dout).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   fifo_param_if.slave bus
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = c_AW + 1;

   localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
   localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
   localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(DEPTH);
   localparam logic [c_CW-1:0] c_AF      = c_CW'(AF_LEVEL);
   localparam logic [c_CW-1:0] c_AE      = c_CW'(AE_LEVEL);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_CW-1:0]  r_count;
   logic             r_full;
   logic             r_empty;
   logic             r_almost_full;
   logic             r_almost_empty;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_wr_ok;
   logic             w_rd_ok;
   logic [c_CW-1:0]  w_count_nxt;

   // Acceptance uses the registered flags; a full FIFO still takes a write
   // when a read frees a slot on the same edge.
   assign w_rd_ok = bus.rd_en && !r_empty;
   assign w_wr_ok = bus.wr_en && (!r_full || bus.rd_en);

   assign w_count_nxt = r_count
                      + (w_wr_ok ? c_CNT_ONE : '0)
                      - (w_rd_ok ? c_CNT_ONE : '0);

   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wr_ptr] <= bus.din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_rd_ok) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         r_count        <= w_count_nxt;
         r_full         <= (w_count_nxt == c_DEPTH);
         r_empty        <= (w_count_nxt == '0);
         r_almost_full  <= (w_count_nxt >= c_AF);
         r_almost_empty <= (w_count_nxt <= c_AE);
      end
   end

   // Error events take priority over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (bus.wr_en && !w_wr_ok) begin
            r_overflow <= 1'b1;
         end else if (bus.clr_err) begin
            r_overflow <= 1'b0;
         end
         if (bus.rd_en && !w_rd_ok) begin
            r_underflow <= 1'b1;
         end else if (bus.clr_err) begin
            r_underflow <= 1'b0;
         end
      end
   end

`ifdef FIFO_FWFT_EN
   assign bus.dout = r_empty ? '0 : r_mem[r_rd_ptr];
`else
   logic [WIDTH-1:0] r_dout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout <= '0;
      end else if (w_rd_ok) begin
         r_dout <= r_mem[r_rd_ptr];
      end
   end

   assign bus.dout = r_dout;
`endif

   assign bus.full         = r_full;
   assign bus.empty        = r_empty;
   assign bus.almost_full  = r_almost_full;
   assign bus.almost_empty = r_almost_empty;
   assign bus.count        = r_count;
   assign bus.overflow     = r_overflow;
   assign bus.underflow    = r_underflow;

endmodule

`default_nettype wire
